conv_mult_ctrl: RTL and testbench
=================================

CONV_MULT_CTRL -- requirements
Module: conv_mult_ctrl

Interface
REQ-001 The block SHALL have parameter K_DIM, default 3, the kernel dimension; the kernel holds K_DIM*K_DIM weights.
REQ-002 The block SHALL have parameter I_DIM, default 8, the image dimension; a frame holds I_DIM*I_DIM pixels.
REQ-003 The block SHALL have parameter M_BITS, default 16, the data width of kernel, pixel and product words.
REQ-004 The block SHALL have parameter I_BITS, default nbits(I_DIM) from utils.sv, the coordinate width; it SHALL equal the value used by the downstream output accumulator.
REQ-005 The block SHALL have port clk, input, 1 bit: the clock.
REQ-006 The block SHALL have port rstn, input, 1 bit: the reset, synchronous and active-low.
REQ-007 The block SHALL have ports k_data (input, M_BITS), k_valid (input, 1), k_ready (output, 1) and k_last (input, 1), forming the kernel-weight stream slave.
REQ-008 The block SHALL have ports img_data (input, M_BITS), img_valid (input, 1), img_ready (output, 1) and img_last (input, 1), forming the pixel stream slave.
REQ-009 The block SHALL have port mult_data, output, [K_DIM-1:0][K_DIM-1:0][M_BITS-1:0]: the per-weight products.
REQ-010 The block SHALL have ports mult_valid (output, 1), mult_ready (input, 1) and mult_last (output, 1), forming the product stream master handshake.
REQ-011 The block SHALL have port mult_user, output, [1:0][I_BITS-1:0]: [1] is the pixel row i and [0] is the pixel column j.
REQ-012 The block SHALL have port err, output, 1 bit: a sticky framing-error flag.

Function
REQ-013 The block SHALL implement the states KLOAD, IMG and FLUSH.
REQ-014 In KLOAD, k_ready SHALL be 1, and it SHALL be 0 in every other state.
REQ-015 In KLOAD, each k_valid&&k_ready transfer SHALL write weight[m][n], with m and n taken in row-major order: word 0 to [0][0], word K_DIM*K_DIM-1 to [K_DIM-1][K_DIM-1].
REQ-016 On the K_DIM*K_DIM-th kernel transfer, the state SHALL become IMG at the next edge and the kernel counter SHALL return to 0.
REQ-017 k_last SHALL NOT control the transition; a transfer where k_last != (word index == K_DIM*K_DIM-1) SHALL set err.
REQ-018 In IMG, img_ready SHALL equal (!mult_valid || mult_ready).
REQ-019 On an img transfer, the block SHALL register mult_data[m][n] = low M_BITS of img_data*weight[m][n]; this is modulo 2^M_BITS, so the result is identical for signed and unsigned operands.
REQ-020 On an img transfer, the block SHALL register mult_user = {row, col} and mult_last = (row==I_DIM-1 && col==I_DIM-1), and SHALL set mult_valid to 1.
REQ-021 Pixel-to-product latency SHALL be 1 cycle: a pixel accepted at edge N SHALL be presented from edge N onward.
REQ-022 Under continuous valid/ready, the block SHALL sustain 1 pixel per cycle.
REQ-023 col SHALL increment per pixel and wrap from I_DIM-1 to 0, incrementing row on the wrap; the pixel order SHALL be raster order.
REQ-024 When mult_valid && !mult_ready, mult_data, mult_user and mult_last SHALL hold stable and no pixel SHALL be accepted.
REQ-025 mult_valid SHALL clear on a mult handshake with no concurrent img transfer; a simultaneous handshake and transfer SHALL load the new beat with mult_valid remaining 1.
REQ-026 On acceptance of pixel I_DIM*I_DIM-1, the state SHALL become FLUSH, row and col SHALL return to 0, and img_ready SHALL be 0.
REQ-027 In FLUSH, the mult handshake of the beat with mult_last=1 SHALL move the state to KLOAD at that edge.
REQ-028 img_last SHALL NOT control framing; a transfer where img_last != (last pixel) SHALL set err.
REQ-029 err SHALL be sticky and SHALL clear only on reset; framing SHALL continue normally after err is set.

Reset
REQ-030 When rstn=0 at a clk edge, the block SHALL set state=KLOAD, all counters to 0, all weights to 0, mult_data to 0, mult_user to 0, mult_last to 0, mult_valid to 0 and err to 0.
REQ-031 While rstn=0, k_ready and img_ready SHALL be 0.
REQ-032 A reset asserted in any state, including mid-frame or with a beat stalled, SHALL discard all in-flight data.

Verification (K_DIM=3, I_DIM=8, M_BITS=16)
REQ-033 The bench SHALL apply reset for 2 cycles then release it, and SHALL check mult_valid=0, err=0, k_ready=1 and img_ready=0.
REQ-034 The bench SHALL load kernel 1..9 then send pixel 2, and SHALL check that the next cycle gives mult_data[m][n]=2*(3m+n+1), mult_user=(0,0) and mult_last=0.
REQ-035 The bench SHALL send weight 0x0100 with pixel 0x0100, and weight 0xFFFF with pixel 0x0003, and SHALL check products 0x0000 and 0xFFFD respectively.
REQ-036 The bench SHALL stream a 64-pixel frame with mult_ready low for 5 cycles at beat 20, and SHALL check: data held stable; exactly 64 beats; mult_last only on beat 64 with user (7,7); then k_ready=1.
REQ-037 The bench SHALL assert k_last on kernel word 5, and SHALL check err=1 from the next cycle, all 9 words still loaded, and IMG entered after word 9.
REQ-038 The bench SHALL assert reset after 20 pixels, and SHALL check that afterwards mult_valid=0, k_ready=1 and a fresh kernel plus frame produces correct products starting at (0,0).

Source files
------------

// File: rtl/conv_mult_ctrl.sv
// conv_mult_ctrl: loads a K_DIM x K_DIM kernel, then multiplies each incoming
// pixel of an I_DIM x I_DIM frame by every weight and streams the products
// with the pixel's raster coordinates. Framing is count-driven; the last flags
// on the input streams are only cross-checked and latch a sticky error.
module conv_mult_ctrl #(
  parameter int unsigned K_DIM  = 3,
  parameter int unsigned I_DIM  = 8,
  parameter int unsigned M_BITS = 16,
  parameter int unsigned I_BITS = (I_DIM > 1) ? $clog2(I_DIM) : 1
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic [M_BITS-1:0]                         k_data,
  input  logic                                      k_valid,
  output logic                                      k_ready,
  input  logic                                      k_last,
  input  logic [M_BITS-1:0]                         img_data,
  input  logic                                      img_valid,
  output logic                                      img_ready,
  input  logic                                      img_last,
  output logic [K_DIM-1:0][K_DIM-1:0][M_BITS-1:0]   mult_data,
  output logic                                      mult_valid,
  input  logic                                      mult_ready,
  output logic                                      mult_last,
  output logic [1:0][I_BITS-1:0]                    mult_user,
  output logic                                      err
);

  localparam int unsigned KC_BITS = (K_DIM > 1) ? $clog2(K_DIM) : 1;

  typedef enum logic [1:0] {
    KLOAD = 2'd0,
    IMG   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                                   r_state;
  logic [KC_BITS-1:0]                       r_km;
  logic [KC_BITS-1:0]                       r_kn;
  logic [K_DIM-1:0][K_DIM-1:0][M_BITS-1:0]  r_weight;
  logic [I_BITS-1:0]                        r_row;
  logic [I_BITS-1:0]                        r_col;
  logic [K_DIM-1:0][K_DIM-1:0][M_BITS-1:0]  r_mult_data;
  logic [1:0][I_BITS-1:0]                   r_mult_user;
  logic                                     r_mult_last;
  logic                                     r_mult_valid;
  logic                                     r_err;

  logic                                     w_k_xfer;
  logic                                     w_img_xfer;
  logic                                     w_mult_hs;
  logic                                     w_k_last_word;
  logic                                     w_kn_wrap;
  logic                                     w_col_wrap;
  logic                                     w_last_pix;
  logic [K_DIM-1:0][K_DIM-1:0][M_BITS-1:0]  w_prod;

  // Ready signals are gated by reset so no transfer is seen while rstn is low
  assign k_ready   = rstn && (r_state == KLOAD);
  assign img_ready = rstn && (r_state == IMG) && (!r_mult_valid || mult_ready);

  assign w_k_xfer   = k_valid && k_ready;
  assign w_img_xfer = img_valid && img_ready;
  assign w_mult_hs  = r_mult_valid && mult_ready;

  assign w_kn_wrap     = (r_kn == KC_BITS'(K_DIM - 1));
  assign w_k_last_word = w_kn_wrap && (r_km == KC_BITS'(K_DIM - 1));
  assign w_col_wrap    = (r_col == I_BITS'(I_DIM - 1));
  assign w_last_pix    = w_col_wrap && (r_row == I_BITS'(I_DIM - 1));

  assign mult_data  = r_mult_data;
  assign mult_user  = r_mult_user;
  assign mult_last  = r_mult_last;
  assign mult_valid = r_mult_valid;
  assign err        = r_err;

  // Pixel times every weight, truncated to M_BITS (sign-agnostic)
  always_comb begin
    w_prod = '0;
    for (int m = 0; m < int'(K_DIM); m++) begin
      for (int n = 0; n < int'(K_DIM); n++) begin
        w_prod[m][n] = M_BITS'(img_data * r_weight[m][n]);
      end
    end
  end

  // Control FSM with kernel/pixel counters and registered product beat
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= KLOAD;
      r_km         <= '0;
      r_kn         <= '0;
      r_weight     <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_mult_data  <= '0;
      r_mult_user  <= '0;
      r_mult_last  <= 1'b0;
      r_mult_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        KLOAD: begin
          if (w_k_xfer) begin
            r_weight[r_km][r_kn] <= k_data;
            if (k_last ^ w_k_last_word) begin
              r_err <= 1'b1;
            end
            if (w_kn_wrap) begin
              r_kn <= '0;
              if (w_k_last_word) begin
                r_km    <= '0;
                r_state <= IMG;
              end else begin
                r_km <= r_km + KC_BITS'(1);
              end
            end else begin
              r_kn <= r_kn + KC_BITS'(1);
            end
          end
        end

        IMG: begin
          if (w_img_xfer) begin
            r_mult_data  <= w_prod;
            r_mult_user  <= {r_row, r_col};
            r_mult_last  <= w_last_pix;
            r_mult_valid <= 1'b1;
            if (img_last ^ w_last_pix) begin
              r_err <= 1'b1;
            end
            if (w_last_pix) begin
              r_row   <= '0;
              r_col   <= '0;
              r_state <= FLUSH;
            end else if (w_col_wrap) begin
              r_col <= '0;
              r_row <= r_row + I_BITS'(1);
            end else begin
              r_col <= r_col + I_BITS'(1);
            end
          end else if (w_mult_hs) begin
            r_mult_valid <= 1'b0;
          end
        end

        FLUSH: begin
          if (w_mult_hs) begin
            r_mult_valid <= 1'b0;
            if (r_mult_last) begin
              r_state <= KLOAD;
            end
          end
        end

        default: begin
          r_state <= KLOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mult_ctrl.sv
// Bench for conv_mult_ctrl (K_DIM=3, I_DIM=8, M_BITS=16): directed and
// randomized frames checked against a plain-arithmetic product/raster model.
module tb_conv_mult_ctrl;

  localparam int K    = 3;
  localparam int I    = 8;
  localparam int M    = 16;
  localparam int IB   = 3;
  localparam int NW   = K * K;
  localparam int NPIX = I * I;

  typedef logic [K-1:0][K-1:0][M-1:0] prod_t;
  typedef struct {
    prod_t data;
    int    row;
    int    col;
    bit    last;
  } beat_t;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [M-1:0]          k_data;
  logic                  k_valid;
  logic                  k_ready;
  logic                  k_last;
  logic [M-1:0]          img_data;
  logic                  img_valid;
  logic                  img_ready;
  logic                  img_last;
  prod_t                 mult_data;
  logic                  mult_valid;
  logic                  mult_ready;
  logic                  mult_last;
  logic [1:0][IB-1:0]    mult_user;
  logic                  err;

  int total = 0;
  int bad   = 0;

  logic [M-1:0] kw [NW];
  logic [M-1:0] pix[NPIX];
  beat_t        exp_q[$];
  int           g_bad_ilast = -1;

  always #5 clk = ~clk;

  conv_mult_ctrl #(
    .K_DIM (K),
    .I_DIM (I),
    .M_BITS(M),
    .I_BITS(IB)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .k_data    (k_data),
    .k_valid   (k_valid),
    .k_ready   (k_ready),
    .k_last    (k_last),
    .img_data  (img_data),
    .img_valid (img_valid),
    .img_ready (img_ready),
    .img_last  (img_last),
    .mult_data (mult_data),
    .mult_valid(mult_valid),
    .mult_ready(mult_ready),
    .mult_last (mult_last),
    .mult_user (mult_user),
    .err       (err)
  );

  // Reference: each product is the full 32-bit product reduced modulo 2^16
  function automatic prod_t model_prod(input logic [M-1:0] px);
    prod_t       r;
    logic [31:0] t;
    for (int m = 0; m < K; m++) begin
      for (int n = 0; n < K; n++) begin
        t = {16'd0, px} * {16'd0, kw[K*m + n]};
        r[m][n] = t[15:0];
      end
    end
    return r;
  endfunction

  function automatic beat_t model_beat(input int p);
    beat_t b;
    b.data = model_prod(pix[p]);
    b.row  = p / I;
    b.col  = p % I;
    b.last = (p == NPIX - 1);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_kernel();
    for (int i = 0; i < NW; i++) kw[i] = M'($urandom);
  endtask

  task automatic rand_pixels();
    for (int p = 0; p < NPIX; p++) pix[p] = M'($urandom);
    pix[$urandom_range(0, NPIX-1)] = 16'hFFFF;
    pix[$urandom_range(0, NPIX-1)] = 16'h0000;
  endtask

  task automatic reset_dut();
    rstn       = 1'b0;
    k_data     = '0;
    k_valid    = 1'b0;
    k_last     = 1'b0;
    img_data   = '0;
    img_valid  = 1'b0;
    img_last   = 1'b0;
    mult_ready = 1'b0;
    repeat (2) tick();
    total++;
    if (k_ready !== 1'b0 || img_ready !== 1'b0)
      $display("FAIL rst_ready: got k_ready=%b img_ready=%b exp 0 0", k_ready, img_ready);
    if (k_ready !== 1'b0 || img_ready !== 1'b0) bad++;
    rstn = 1'b1;
    exp_q.delete();
    #1;
  endtask

  task automatic load_kernel(input int klast_idx, input bit gaps);
    for (int i = 0; i < NW; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          k_valid = 1'b0;
          tick();
        end
      end
      k_data  = kw[i];
      k_valid = 1'b1;
      k_last  = (i == klast_idx);
      #1;
      total++;
      if (k_ready !== 1'b1) begin
        bad++;
        $display("FAIL kload_ready word %0d: got %b exp 1", i, k_ready);
      end
      tick();
      if (i == klast_idx && klast_idx != NW - 1) begin
        total++;
        if (err !== 1'b1) begin
          bad++;
          $display("FAIL klast_err: got err=%b exp 1", err);
        end
      end
    end
    k_valid = 1'b0;
    k_last  = 1'b0;
    #1;
    total++;
    if (k_ready !== 1'b0) begin
      bad++;
      $display("FAIL kload_exit: got k_ready=%b exp 0", k_ready);
    end
  endtask

  // Streams pixels first_p.. with the model scoreboard; returns early once
  // stop_p pixels have been accepted (stop_p < NPIX)
  task automatic run_frame(input int first_p, input int stop_p, input int stall_beat,
                           input int stall_len, input bit rnd);
    int                 p;
    int                 beats;
    int                 stall_cnt;
    int                 cycles;
    int                 q0;
    bit                 stall_done;
    bit                 held;
    bit                 flush_chk;
    bit                 w_img;
    bit                 w_hs;
    prod_t              h_data;
    logic [1:0][IB-1:0] h_user;
    logic               h_last;
    beat_t              e;
    p          = first_p;
    beats      = 0;
    stall_cnt  = 0;
    cycles     = 0;
    q0         = exp_q.size();
    stall_done = (stall_beat < 0);
    held       = 1'b0;
    flush_chk  = 1'b0;
    h_data     = '0;
    h_user     = '0;
    h_last     = 1'b0;
    while (!(p == NPIX && exp_q.size() == 0)) begin
      if (cycles >= 4000) begin
        total++;
        bad++;
        $display("FAIL frame_timeout: got %0d pixels %0d beats exp %0d pixels", p, beats, NPIX);
        break;
      end
      img_valid = (p < NPIX) && (!rnd || $urandom_range(0, 3) != 0);
      img_data  = '0;
      if (p < NPIX) img_data = pix[p];
      img_last  = (p == NPIX - 1) ^ (p == g_bad_ilast);
      if (!stall_done && mult_valid === 1'b1 && beats == stall_beat - 1) begin
        mult_ready = 1'b0;
        stall_cnt++;
        if (stall_cnt == stall_len) stall_done = 1'b1;
      end else begin
        mult_ready = !rnd || ($urandom_range(0, 2) != 0);
      end
      #1;
      w_img = img_valid && (img_ready === 1'b1);
      w_hs  = (mult_valid === 1'b1) && mult_ready;
      if (held) begin
        total++;
        if (mult_data !== h_data || mult_user !== h_user || mult_last !== h_last) begin
          bad++;
          $display("FAIL hold: got data=%h user=%h last=%b exp data=%h user=%h last=%b",
                   mult_data, mult_user, mult_last, h_data, h_user, h_last);
        end
      end
      if (mult_valid === 1'b1 && !mult_ready) begin
        total++;
        if (img_ready !== 1'b0) begin
          bad++;
          $display("FAIL stall_ready: got img_ready=%b exp 0", img_ready);
        end
      end
      if (p == NPIX && !flush_chk) begin
        flush_chk = 1'b1;
        total++;
        if (img_ready !== 1'b0) begin
          bad++;
          $display("FAIL flush_ready: got img_ready=%b exp 0", img_ready);
        end
      end
      if (w_hs) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_beat: got beat user=%h exp none", mult_user);
        end else begin
          e = exp_q.pop_front();
          if (mult_data !== e.data || mult_user[1] !== IB'(e.row) ||
              mult_user[0] !== IB'(e.col) || mult_last !== e.last) begin
            bad++;
            $display("FAIL beat %0d: got data=%h row=%0d col=%0d last=%b exp data=%h row=%0d col=%0d last=%b",
                     beats, mult_data, mult_user[1], mult_user[0], mult_last,
                     e.data, e.row, e.col, e.last);
          end
        end
        beats++;
      end
      if (w_img) begin
        exp_q.push_back(model_beat(p));
        p++;
      end
      held   = (mult_valid === 1'b1) && !mult_ready;
      h_data = mult_data;
      h_user = mult_user;
      h_last = mult_last;
      tick();
      cycles++;
      if (stop_p < NPIX && p == stop_p) begin
        img_valid  = 1'b0;
        mult_ready = 1'b0;
        return;
      end
    end
    img_valid  = 1'b0;
    img_last   = 1'b0;
    mult_ready = 1'b1;
    #1;
    total++;
    if (beats !== (NPIX - first_p) + q0) begin
      bad++;
      $display("FAIL beat_count: got %0d exp %0d", beats, (NPIX - first_p) + q0);
    end
    total++;
    if (mult_valid !== 1'b0 || k_ready !== 1'b1) begin
      bad++;
      $display("FAIL frame_end: got mult_valid=%b k_ready=%b exp 0 1", mult_valid, k_ready);
    end
    tick();
    total++;
    if (mult_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_frame: got mult_valid=%b exp 0", mult_valid);
    end
    mult_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    total++;
    if (mult_valid !== 1'b0) begin bad++; $display("FAIL rst_mult_valid: got %b exp 0", mult_valid); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b exp 0", err); end
    total++;
    if (k_ready !== 1'b1) begin bad++; $display("FAIL rst_k_ready: got %b exp 1", k_ready); end
    total++;
    if (img_ready !== 1'b0) begin bad++; $display("FAIL rst_img_ready: got %b exp 0", img_ready); end
    total++;
    if (mult_data !== '0 || mult_user !== '0 || mult_last !== 1'b0) begin
      bad++;
      $display("FAIL rst_outputs: got data=%h user=%h last=%b exp 0", mult_data, mult_user, mult_last);
    end
  endtask

  task automatic test_basic();
    prod_t e;
    for (int i = 0; i < NW; i++) kw[i] = M'(i + 1);
    load_kernel(NW - 1, 1'b0);
    rand_pixels();
    pix[0]     = 16'd2;
    img_data   = 16'd2;
    img_valid  = 1'b1;
    img_last   = 1'b0;
    mult_ready = 1'b0;
    #1;
    tick();
    img_valid = 1'b0;
    for (int m = 0; m < K; m++)
      for (int n = 0; n < K; n++)
        e[m][n] = 16'(2 * (3*m + n + 1));
    total++;
    if (mult_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b exp 1", mult_valid); end
    total++;
    if (mult_data !== e) begin bad++; $display("FAIL basic_data: got %h exp %h", mult_data, e); end
    total++;
    if (mult_user[1] !== 3'd0 || mult_user[0] !== 3'd0) begin
      bad++;
      $display("FAIL basic_user: got (%0d,%0d) exp (0,0)", mult_user[1], mult_user[0]);
    end
    total++;
    if (mult_last !== 1'b0) begin bad++; $display("FAIL basic_last: got %b exp 0", mult_last); end
    exp_q.push_back(model_beat(0));
    run_frame(1, NPIX, -1, 0, 1'b1);
  endtask

  task automatic test_products();
    rand_kernel();
    kw[0] = 16'h0100;
    kw[1] = 16'hFFFF;
    load_kernel(NW - 1, 1'b1);
    rand_pixels();
    pix[0]     = 16'h0100;
    pix[1]     = 16'h0003;
    img_data   = pix[0];
    img_valid  = 1'b1;
    img_last   = 1'b0;
    mult_ready = 1'b0;
    #1;
    tick();
    total++;
    if (mult_data[0][0] !== 16'h0000) begin
      bad++;
      $display("FAIL prod_wrap: got %h exp 0000", mult_data[0][0]);
    end
    img_data   = pix[1];
    img_valid  = 1'b1;
    mult_ready = 1'b1;
    #1;
    tick();
    img_valid  = 1'b0;
    mult_ready = 1'b0;
    total++;
    if (mult_valid !== 1'b1 || mult_user[0] !== 3'd1) begin
      bad++;
      $display("FAIL b2b_load: got valid=%b col=%0d exp 1 1", mult_valid, mult_user[0]);
    end
    total++;
    if (mult_data[0][1] !== 16'hFFFD) begin
      bad++;
      $display("FAIL prod_neg: got %h exp fffd", mult_data[0][1]);
    end
    exp_q.push_back(model_beat(1));
    run_frame(2, NPIX, -1, 0, 1'b1);
  endtask

  task automatic test_stall_frame();
    rand_kernel();
    load_kernel(NW - 1, 1'b0);
    rand_pixels();
    run_frame(0, NPIX, 20, 5, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      rand_kernel();
      kw[$urandom_range(0, NW-1)] = 16'hFFFF;
      load_kernel(NW - 1, 1'b1);
      rand_pixels();
      run_frame(0, NPIX, -1, 0, 1'b1);
    end
  endtask

  task automatic test_klast_err();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL pre_klast_err: got %b exp 0", err); end
    rand_kernel();
    load_kernel(4, 1'b0);
    rand_pixels();
    run_frame(0, NPIX, -1, 0, 1'b1);
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b exp 1", err); end
  endtask

  task automatic test_reset_mid();
    rand_kernel();
    load_kernel(NW - 1, 1'b0);
    rand_pixels();
    run_frame(0, 20, -1, 0, 1'b1);
    reset_dut();
    total++;
    if (mult_valid !== 1'b0 || k_ready !== 1'b1 || img_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got valid=%b k_ready=%b img_ready=%b exp 0 1 0",
               mult_valid, k_ready, img_ready);
    end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL mid_reset_err: got %b exp 0", err); end
    rand_kernel();
    load_kernel(NW - 1, 1'b1);
    rand_pixels();
    run_frame(0, NPIX, -1, 0, 1'b1);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL clean_err: got %b exp 0", err); end
  endtask

  task automatic test_ilast_err();
    rand_kernel();
    load_kernel(NW - 1, 1'b0);
    rand_pixels();
    g_bad_ilast = 10;
    run_frame(0, NPIX, -1, 0, 1'b1);
    g_bad_ilast = -1;
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL ilast_err: got %b exp 1", err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_products();
    test_stall_frame();
    test_back_to_back();
    test_klast_err();
    test_reset_mid();
    test_ilast_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish exp finish before time limit");
    $fatal(1);
  end

endmodule
